pipe_stage_reg: RTL

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

---
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register with flush and a saturating back-pressure counter.
// Define PIPE_SKID_EN to add a skid register so that in_ready comes straight from a flop.
module pipe_stage_reg #(
   parameter int unsigned           WIDTH     = 32,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0,
   parameter int unsigned           CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   input  logic             flush,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt
);

   logic             in_xfer;
   logic [WIDTH-1:0] main_d;

   assign in_xfer  = in_valid & in_ready;
   assign out_data = main_d;

`ifdef PIPE_SKID_EN
   // Bit 0 is the main valid flag, bit 1 the skid valid flag.
   typedef enum logic [1:0] {
      EMPTY = 2'b00,
      ONE   = 2'b01,
      TWO   = 2'b11
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] skid_d;

   assign out_valid = state[0];
   assign in_ready  = ~state[1];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         main_d <= RESET_VAL;
         skid_d <= RESET_VAL;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state  <= ONE;
                  main_d <= in_data;
               end
            end
            ONE: begin
               if (in_xfer && out_ready) begin
                  main_d <= in_data;
               end else if (in_xfer) begin
                  state  <= TWO;
                  skid_d <= in_data;
               end else if (out_ready) begin
                  state <= EMPTY;
               end
            end
            TWO: begin
               if (out_ready) begin
                  state  <= ONE;
                  main_d <= skid_d;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
`else
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;

   assign out_valid = (state == FULL);
   assign in_ready  = (state == EMPTY) | out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= EMPTY;
         main_d <= RESET_VAL;
      end else if (flush) begin
         state <= EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (in_xfer) begin
                  state  <= FULL;
                  main_d <= in_data;
               end
            end
            FULL: begin
               // An input transfer while FULL implies out_ready, so the slot is replaced.
               if (in_xfer) begin
                  main_d <= in_data;
               end else if (out_ready) begin
                  state <= EMPTY;
               end
            end
            default: state <= EMPTY;
         endcase
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && !(&stall_cnt)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
